// File: rtl/lsu.sv
// Load/store unit: registered request/ready bus master with byte-lane alignment and load extension.
// Optional macro LSU_MISALIGN_SPLIT_EN splits bus-word-crossing accesses into two beats instead of trapping.
module lsu #(
  parameter int ADDR_WIDTH = 31,
  parameter int DATA_WIDTH = 31
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_en,
  input  logic                    i_valid,
  input  logic                    i_is_store,
  input  logic [2:0]              i_funct3,
  input  logic [31:0]             i_base,
  input  logic [31:0]             i_imm,
  input  logic [31:0]             i_store_data,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [31:0]             o_load_data,
  output logic                    o_misaligned,
  output logic                    o_mem_req,
  output logic                    o_mem_we,
  output logic [ADDR_WIDTH:0]     o_mem_addr,
  output logic [(DATA_WIDTH+1)/8-1:0] o_mem_be,
  output logic [DATA_WIDTH:0]     o_mem_wdata,
  input  logic                    i_mem_ready,
  input  logic [DATA_WIDTH:0]     i_mem_rdata
);

  localparam int DW    = DATA_WIDTH + 1;
  localparam int AW    = ADDR_WIDTH + 1;
  localparam int LANES = DW / 8;
  localparam int OFS   = $clog2(LANES);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  state_t             state_q, state_d;
  logic               we_q, we_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [LANES-1:0]   be_q, be_d;
  logic [LANES-1:0]   be_hi_q, be_hi_d;
  logic [DW-1:0]      wdata_q, wdata_d;
  logic [DW-1:0]      wdata_hi_q, wdata_hi_d;
  logic [DW-1:0]      rdata0_q, rdata0_d;
  logic [OFS-1:0]     off_q, off_d;
  logic [1:0]         size_q, size_d;
  logic               sign_q, sign_d;
  logic               split_q, split_d;
  logic [31:0]        load_data_q, load_data_d;
  logic               mis_q, mis_d;

  logic [31:0]        ea;
  logic [31:0]        word_idx;
  logic [OFS-1:0]     off;
  logic [1:0]         size;
  logic [2:0]         nbytes;
  logic [3:0]         mask;
  logic [31:0]        dmask;
  logic               legal;
  logic               trap;
  logic               split_n;
  logic [2*LANES-1:0] be_w;
  logic [2*DW-1:0]    wd_w;

  // Select the addressed bytes out of a (possibly two-beat) read window and extend to 32 bits.
  function automatic logic [31:0] extend_load(input logic [2*DW-1:0] wide,
                                              input logic [OFS-1:0]  ofs,
                                              input logic [1:0]      sz,
                                              input logic            sgn);
    logic [31:0] sh;
    sh = 32'(wide >> {ofs, 3'b000});
    case (sz)
      2'd0:    extend_load = sgn ? {{24{sh[7]}}, sh[7:0]} : {24'h0, sh[7:0]};
      2'd1:    extend_load = sgn ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
      default: extend_load = sh;
    endcase
  endfunction

  always_comb begin
    ea       = i_base + i_imm;
    word_idx = ea >> OFS;
    off      = ea[OFS-1:0];
    size     = i_funct3[1:0];
    case (size)
      2'd0:    begin nbytes = 3'd1; mask = 4'h1; dmask = 32'h0000_00FF; end
      2'd1:    begin nbytes = 3'd2; mask = 4'h3; dmask = 32'h0000_FFFF; end
      default: begin nbytes = 3'd4; mask = 4'hF; dmask = 32'hFFFF_FFFF; end
    endcase
    legal = i_is_store ? (i_funct3 inside {3'd0, 3'd1, 3'd2})
                       : (i_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
`ifdef LSU_MISALIGN_SPLIT_EN
    trap    = 1'b0;
    split_n = ((OFS+2)'(off) + (OFS+2)'(nbytes)) > (OFS+2)'(LANES);
`else
    trap    = ((size == 2'd1) && ea[0]) || ((size == 2'd2) && (ea[1:0] != 2'b00));
    split_n = 1'b0;
`endif
    // Lanes/bytes above the first bus word become the second beat of a split access.
    be_w = (2*LANES)'(mask) << off;
    wd_w = (2*DW)'(i_store_data & dmask) << {off, 3'b000};

    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    be_d        = be_q;
    be_hi_d     = be_hi_q;
    wdata_d     = wdata_q;
    wdata_hi_d  = wdata_hi_q;
    rdata0_d    = rdata0_q;
    off_d       = off_q;
    size_d      = size_q;
    sign_d      = sign_q;
    split_d     = split_q;
    load_data_d = load_data_q;
    mis_d       = mis_q;

    case (state_q)
      IDLE: begin
        if (i_valid) begin
          load_data_d = 32'h0;
          mis_d       = 1'b0;
          if (!legal) begin
            state_d = RESP;
          end else if (trap) begin
            mis_d   = 1'b1;
            state_d = RESP;
          end else begin
            we_d       = i_is_store;
            addr_d     = AW'(word_idx);
            be_d       = be_w[LANES-1:0];
            be_hi_d    = be_w[2*LANES-1:LANES];
            wdata_d    = wd_w[DW-1:0];
            wdata_hi_d = wd_w[2*DW-1:DW];
            off_d      = off;
            size_d     = size;
            sign_d     = ~i_funct3[2];
            split_d    = split_n;
            state_d    = BEAT0;
          end
        end
      end
      BEAT0: begin
        if (i_mem_ready) begin
          if (split_q) begin
            rdata0_d = i_mem_rdata;
            addr_d   = addr_q + AW'(1);
            be_d     = be_hi_q;
            wdata_d  = wdata_hi_q;
            state_d  = BEAT1;
          end else begin
            load_data_d = we_q ? 32'h0
                               : extend_load({{DW{1'b0}}, i_mem_rdata}, off_q, size_q, sign_q);
            state_d     = RESP;
          end
        end
      end
      BEAT1: begin
        if (i_mem_ready) begin
          load_data_d = we_q ? 32'h0
                             : extend_load({i_mem_rdata, rdata0_q}, off_q, size_q, sign_q);
          state_d     = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      be_hi_q     <= '0;
      wdata_q     <= '0;
      wdata_hi_q  <= '0;
      rdata0_q    <= '0;
      off_q       <= '0;
      size_q      <= 2'd0;
      sign_q      <= 1'b0;
      split_q     <= 1'b0;
      load_data_q <= 32'h0;
      mis_q       <= 1'b0;
    end else if (clk_en) begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      be_hi_q     <= be_hi_d;
      wdata_q     <= wdata_d;
      wdata_hi_q  <= wdata_hi_d;
      rdata0_q    <= rdata0_d;
      off_q       <= off_d;
      size_q      <= size_d;
      sign_q      <= sign_d;
      split_q     <= split_d;
      load_data_q <= load_data_d;
      mis_q       <= mis_d;
    end
  end

  assign o_mem_req    = (state_q == BEAT0) || (state_q == BEAT1);
  assign o_busy       = ((state_q == IDLE) && i_valid) || o_mem_req;
  assign o_done       = (state_q == RESP);
  assign o_load_data  = load_data_q;
  assign o_misaligned = mis_q;
  assign o_mem_we     = we_q;
  assign o_mem_addr   = addr_q;
  assign o_mem_be     = be_q;
  assign o_mem_wdata  = wdata_q;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: byte-level reference memory predicts bus beats and load results.
module tb_lsu;
  logic        clk = 1'b0;
  logic        rst, clk_en, i_valid, i_is_store;
  logic [2:0]  i_funct3;
  logic [31:0] i_base, i_imm, i_store_data;
  logic        o_busy, o_done, o_misaligned, o_mem_req, o_mem_we;
  logic [31:0] o_load_data, o_mem_addr, o_mem_wdata, i_mem_rdata;
  logic [3:0]  o_mem_be;
  logic        i_mem_ready;

  always #5 clk = ~clk;

  lsu dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .i_valid(i_valid), .i_is_store(i_is_store),
    .i_funct3(i_funct3), .i_base(i_base), .i_imm(i_imm), .i_store_data(i_store_data),
    .o_busy(o_busy), .o_done(o_done), .o_load_data(o_load_data), .o_misaligned(o_misaligned),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_be(o_mem_be),
    .o_mem_wdata(o_mem_wdata), .i_mem_ready(i_mem_ready), .i_mem_rdata(i_mem_rdata)
  );

  typedef struct { logic [31:0] addr; logic [3:0] be; logic we; logic [31:0] wdata; } beat_t;
  typedef struct { logic [31:0] data; logic mis; logic chk_data; } resp_t;

  logic [31:0] mem [0:511];
  logic [7:0]  ref_mem [0:2047];
  beat_t       beat_q[$];
  resp_t       resp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          wait_cfg = 0;
  bit          rnd_mode = 1'b0;
  logic [31:0] last_data = 32'h0;
  logic        last_mis = 1'b0;

  assign i_mem_rdata = mem[o_mem_addr[8:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: walk the accessed bytes one at a time; each new bus word starts a new beat.
  task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] base,
                       input logic [31:0] imm, input logic [31:0] data, output int exp_lat);
    logic [31:0] ea, a, v;
    int nb, nbeats;
    bit legal, trap;
    beat_t b;
    resp_t r;
    ea    = base + imm;
    legal = st ? (f3 <= 3'd2) : (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    nb    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
`ifdef LSU_MISALIGN_SPLIT_EN
    trap = 1'b0;
`else
    trap = (ea % nb) != 0;
`endif
    r.data = 32'h0; r.mis = 1'b0; r.chk_data = 1'b1;
    exp_lat = 1;
    if (!legal) begin
      resp_q.push_back(r);
    end else if (trap) begin
      r.mis = 1'b1;
      resp_q.push_back(r);
    end else begin
      nbeats = 0;
      v = 32'h0;
      b.addr = 32'h0; b.be = 4'h0; b.we = st; b.wdata = 32'h0;
      for (int i = 0; i < nb; i++) begin
        a = ea + i;
        if (nbeats == 0 || b.addr != (a >> 2)) begin
          if (nbeats != 0) beat_q.push_back(b);
          b.addr = a >> 2; b.be = 4'h0; b.we = st; b.wdata = 32'h0;
          nbeats++;
        end
        b.be[a[1:0]] = 1'b1;
        b.wdata[8*a[1:0] +: 8] = data[8*i +: 8];
        if (st) ref_mem[a[10:0]] = data[8*i +: 8];
        else    v[8*i +: 8] = ref_mem[a[10:0]];
      end
      beat_q.push_back(b);
      if (f3 == 3'd0) v = {{24{v[7]}}, v[7:0]};
      if (f3 == 3'd1) v = {{16{v[15]}}, v[15:0]};
      r.data = v; r.chk_data = ~st;
      resp_q.push_back(r);
      exp_lat = 1 + nbeats + wait_cfg;
    end
  endtask

  // Bus slave: checks every presented beat against the queue head, accepts, updates memory.
  initial begin
    int waits_left;
    beat_t e;
    logic [31:0] bm;
    waits_left = 0;
    i_mem_ready = 1'b0;
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
    forever begin
      @(negedge clk);
      if (!o_mem_req) begin
        waits_left = wait_cfg;
        i_mem_ready = 1'b0;
      end else begin
        if (beat_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_req actual=%h expected=none", o_mem_addr);
        end else begin
          e = beat_q[0];
          bm = {{8{e.be[3]}}, {8{e.be[2]}}, {8{e.be[1]}}, {8{e.be[0]}}};
          chk("bus_addr", o_mem_addr, e.addr);
          chk("bus_be", 32'(o_mem_be), 32'(e.be));
          chk("bus_we", 32'(o_mem_we), 32'(e.we));
          if (e.we) chk("bus_wdata", o_mem_wdata & bm, e.wdata & bm);
        end
        if (waits_left > 0) begin
          i_mem_ready = 1'b0;
          if (clk_en) waits_left--;
        end else begin
          i_mem_ready = rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        if (i_mem_ready && clk_en && beat_q.size() != 0) begin
          if (o_mem_we)
            for (int l = 0; l < 4; l++)
              if (o_mem_be[l]) mem[o_mem_addr[8:0]][8*l +: 8] = o_mem_wdata[8*l +: 8];
          void'(beat_q.pop_front());
        end
      end
    end
  end

  // Completion monitor.
  initial begin
    resp_t r;
    forever begin
      @(negedge clk);
      if (o_done && clk_en) begin
        if (resp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done actual=%h expected=none", o_load_data);
        end else begin
          r = resp_q.pop_front();
          chk("misaligned", 32'(o_misaligned), 32'(r.mis));
          if (r.chk_data) chk("load_data", o_load_data, r.data);
        end
        last_data = o_load_data;
        last_mis  = o_misaligned;
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_req"}, 32'(o_mem_req), 32'h0);
    chk({tag, "_done"}, 32'(o_done), 32'h0);
    chk({tag, "_busy"}, 32'(o_busy), 32'h0);
    chk({tag, "_we"}, 32'(o_mem_we), 32'h0);
    chk({tag, "_addr"}, o_mem_addr, 32'h0);
    chk({tag, "_be"}, 32'(o_mem_be), 32'h0);
    chk({tag, "_wdata"}, o_mem_wdata, 32'h0);
    chk({tag, "_ldata"}, o_load_data, 32'h0);
    chk({tag, "_mis"}, 32'(o_misaligned), 32'h0);
  endtask

  // Entered and left just after a rising edge.
  task automatic do_op(input logic st, input logic [2:0] f3, input logic [31:0] base,
                       input logic [31:0] imm, input logic [31:0] data,
                       input int waits, input int stall, input bit chk_lat);
    int exp_lat, lat;
    wait_cfg = waits;
    model(st, f3, base, imm, data, exp_lat);
    exp_lat += stall;
    i_valid = 1'b1; i_is_store = st; i_funct3 = f3;
    i_base = base; i_imm = imm; i_store_data = data;
    #1 chk("busy_on_issue", 32'(o_busy), 32'h1);
    @(posedge clk); #1;
    i_valid = 1'b0;
    lat = 1;
    if (stall > 0) begin
      clk_en = 1'b0;
      repeat (stall) begin
        chk("req_hold", 32'(o_mem_req), 32'h1);
        @(posedge clk); #1;
        lat++;
      end
      clk_en = 1'b1;
    end
    while (!o_done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!o_done) begin
      checks++; errors++;
      $display("FAIL done_timeout actual=%0d expected=%0d", lat, exp_lat);
    end else if (chk_lat) begin
      chk("latency", 32'(lat), 32'(exp_lat));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int dummy;
    rst = 1'b1; clk_en = 1'b1; i_valid = 1'b0; i_is_store = 1'b0; i_funct3 = 3'd0;
    i_base = 32'h0; i_imm = 32'h0; i_store_data = 32'h0;
    for (int i = 0; i < 2048; i++) ref_mem[i] = 8'h0;
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    do_op(1'b1, 3'd2, 32'h100, 32'h0, 32'h80AABBCC, 0, 0, 1'b1);
    do_op(1'b0, 3'd0, 32'h100, 32'h3, 32'h0, 0, 0, 1'b1);
    chk("lb_value", last_data, 32'hFFFFFF80);
    do_op(1'b0, 3'd4, 32'h100, 32'h3, 32'h0, 0, 0, 1'b1);
    chk("lbu_value", last_data, 32'h00000080);
    do_op(1'b1, 3'd1, 32'h200, 32'h2, 32'h1234ABCD, 3, 0, 1'b1);
    do_op(1'b0, 3'd2, 32'h200, 32'h0, 32'h0, 0, 0, 1'b1);
    chk("sh_readback", last_data, 32'hABCD0000);

    do_op(1'b1, 3'd2, 32'h3FC, 32'h0, 32'h55660000, 0, 0, 1'b1);
    do_op(1'b1, 3'd2, 32'h400, 32'h0, 32'h00007788, 0, 0, 1'b1);
    do_op(1'b0, 3'd2, 32'h400, 32'hFFFFFFFE, 32'h0, 0, 0, 1'b1);
`ifdef LSU_MISALIGN_SPLIT_EN
    chk("lw_split_value", last_data, 32'h77885566);
    chk("lw_split_mis", 32'(last_mis), 32'h0);
`else
    chk("lw_trap_mis", 32'(last_mis), 32'h1);
    chk("lw_trap_value", last_data, 32'h0);
`endif
    do_op(1'b0, 3'd3, 32'h100, 32'h0, 32'h0, 0, 0, 1'b1);
    chk("f3_invalid_value", last_data, 32'h0);
    do_op(1'b0, 3'd2, 32'h100, 32'h0, 32'h0, 0, 2, 1'b1);
    chk("clken_value", last_data, 32'h80AABBCC);

    wait_cfg = 10;
    model(1'b0, 3'd2, 32'h100, 32'h0, 32'h0, dummy);
    i_valid = 1'b1; i_is_store = 1'b0; i_funct3 = 3'd2; i_base = 32'h100; i_imm = 32'h0;
    @(posedge clk); #1;
    i_valid = 1'b0;
    chk("beat0_req", 32'(o_mem_req), 32'h1);
    #2 rst = 1'b1;
    #1 check_zero("rst_mid");
    resp_q.delete();
    beat_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_op(1'b0, 3'd4, 32'h100, 32'h3, 32'h0, 0, 0, 1'b1);
    chk("after_rst_value", last_data, 32'h00000080);

    rnd_mode = 1'b1;
    repeat (300) begin
      do_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 32'($urandom_range(8, 32'h7F0)),
            32'($urandom_range(0, 16)) - 32'd8, $urandom, $urandom_range(0, 2), 0, 1'b0);
    end
    rnd_mode = 1'b0;

    chk("resp_q_empty", 32'(resp_q.size()), 32'h0);
    chk("beat_q_empty", 32'(beat_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
